// File: rtl/bin2onehot_pkg.sv
// Shared constants and width helpers for the pipelined binary-to-one-hot decoder.
// BIN2OH_RANGE_CHECK_EN adds an out-of-range error bit to the stage-2 payload.
package bin2onehot_pkg;

   localparam int unsigned W_DEF = 4;
   localparam int unsigned N_DEF = 16;

`ifdef BIN2OH_RANGE_CHECK_EN
   localparam int unsigned ERR_BITS = 1;
`else
   localparam int unsigned ERR_BITS = 0;
`endif

   // Index width needed to address n one-hot lines.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Stage payload width: one-hot vector plus optional error bit.
   function automatic int unsigned stage_width(input int unsigned n, input int unsigned err_bits);
      return n + err_bits;
   endfunction

endpackage

// File: rtl/bin2onehot_pipe_if.sv
// Valid/ready bus between the decoder and its producer/consumer.
// BIN2OH_RANGE_CHECK_EN adds out_err alongside out_onehot.
interface bin2onehot_pipe_if
   import bin2onehot_pkg::*;
#(
   parameter int unsigned W = W_DEF,
   parameter int unsigned N = N_DEF
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_bin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_onehot;
`ifdef BIN2OH_RANGE_CHECK_EN
   logic         out_err;
`endif

`ifdef BIN2OH_RANGE_CHECK_EN
   modport master (
      output in_valid, in_bin, out_ready,
      input  in_ready, out_valid, out_onehot, out_err
   );
   modport slave (
      input  in_valid, in_bin, out_ready,
      output in_ready, out_valid, out_onehot, out_err
   );
`else
   modport master (
      output in_valid, in_bin, out_ready,
      input  in_ready, out_valid, out_onehot
   );
   modport slave (
      input  in_valid, in_bin, out_ready,
      output in_ready, out_valid, out_onehot
   );
`endif

endinterface

// File: rtl/bin2onehot_pipe_stage.sv
// Generic full-throughput valid/ready register slice with synchronous active-low reset.
module pipe_stage #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   // Slice can take a new word when empty or when its current word leaves this cycle.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/bin2onehot_pipe.sv
// Two-stage pipelined binary-to-one-hot decoder with valid/ready on both sides.
// BIN2OH_RANGE_CHECK_EN registers an out-of-range flag (in_bin >= N) with the vector.
module bin2onehot_pipe
   import bin2onehot_pkg::*;
#(
   parameter int unsigned W = W_DEF,
   parameter int unsigned N = N_DEF
) (
   input logic               clk,
   input logic               rstn,
   bin2onehot_pipe_if.slave  bus
);

   localparam int unsigned SW = stage_width(N, ERR_BITS);

   logic         s1_valid;
   logic         s1_ready;
   logic [W-1:0] s1_bin;
   logic [N-1:0] oh_c;
   logic [SW-1:0] dec_c;
   logic [SW-1:0] s2_data;

   pipe_stage #(.DW(W)) u_s1 (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (bus.in_bin),
      .out_valid (s1_valid),
      .out_ready (s1_ready),
      .out_data  (s1_bin)
   );

   // Out-of-range indices match no line and decode to all zeros.
   always_comb begin
      oh_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         oh_c[i] = (32'(s1_bin) == i);
      end
   end

`ifdef BIN2OH_RANGE_CHECK_EN
   logic err_c;

   generate
      if (N < (32'd1 << W)) begin : g_range_gap
         assign err_c = (32'(s1_bin) >= N);
      end else begin : g_full_range
         assign err_c = 1'b0;
      end
   endgenerate

   assign dec_c = {err_c, oh_c};
`else
   assign dec_c = oh_c;
`endif

   pipe_stage #(.DW(SW)) u_s2 (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (s1_valid),
      .in_ready  (s1_ready),
      .in_data   (dec_c),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (s2_data)
   );

   assign bus.out_onehot = s2_data[N-1:0];
`ifdef BIN2OH_RANGE_CHECK_EN
   assign bus.out_err = s2_data[N];
`endif

endmodule

// File: tb/tb_bin2onehot_pipe.sv
// Self-checking bench for bin2onehot_pipe: a token-queue reference model checks
// every cycle of directed and random traffic; a second N=10 instance covers out-of-range.
module tb_bin2onehot_pipe;

   localparam int unsigned W  = 4;
   localparam int unsigned N  = 16;
   localparam int unsigned N2 = 10;

   logic clk;
   logic rstn;

   bin2onehot_pipe_if #(.W(W), .N(N))  bus  ();
   bin2onehot_pipe_if #(.W(W), .N(N2)) bus2 ();

   bin2onehot_pipe #(.W(W), .N(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   bin2onehot_pipe #(.W(W), .N(N2)) dut2 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] oh;
      int          acc_edge;
   } tok_t;

   tok_t q[$];
   int   n_cmp     = 0;
   int   n_err     = 0;
   int   edge_n    = 0;
   int   n_acc     = 0;
   int   n_in_obs  = 0;
   int   n_out_obs = 0;
   bit   known     = 1'b0;
   bit   prev_rst  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the model, drive inputs, advance the model.
   task automatic cycle(input bit iv, input int ib, input bit ordy, input bit rn);
      bit   exp_v;
      bit   exp_rdy;
      bit   acc;
      bit   cons;
      tok_t t;
      exp_v = known && (q.size() > 0) && (edge_n >= q[0].acc_edge + 1);
      if (known) begin
         chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
         if (exp_v) chk("out_onehot", 32'(bus.out_onehot), q[0].oh);
         if (prev_rst) chk("rst_onehot", 32'(bus.out_onehot), 32'd0);
`ifdef BIN2OH_RANGE_CHECK_EN
         chk("out_err_full_range", 32'(bus.out_err), 32'd0);
`endif
      end
      bus.in_valid  = iv;
      bus.in_bin    = 4'(ib);
      bus.out_ready = ordy;
      rstn          = rn;
      #1;
      exp_rdy = !((q.size() == 2) && !ordy);
      if (known && rn) chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (rn && bus.in_valid && bus.in_ready)   n_in_obs++;
      if (rn && bus.out_valid && bus.out_ready) n_out_obs++;
      acc  = rn && iv && exp_rdy;
      cons = rn && exp_v && ordy;
      @(posedge clk);
      edge_n++;
      if (!rn) begin
         q.delete();
         known    = 1'b1;
         prev_rst = 1'b1;
      end else begin
         prev_rst = 1'b0;
         if (cons) void'(q.pop_front());
         if (acc) begin
            t.oh       = (ib < int'(N)) ? (32'd1 << ib) : 32'd0;
            t.acc_edge = edge_n;
            q.push_back(t);
            n_acc++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int guard;
      rstn           = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_bin     = '0;
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_bin    = '0;
      bus2.out_ready = 1'b1;
      @(negedge clk);

      // Reset held with in_valid asserted, then release.
      for (int i = 0; i < 3; i++) cycle(1'b1, 5, 1'b1, 1'b0);
      chk("rst_in_ready_pre", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 2; i++) cycle(1'b0, 0, 1'b1, 1'b1);

      // Streaming 0..15 at full rate.
      for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b1);

      // Backpressure: 3,7,12 with a 4-cycle stall once output is valid.
      cycle(1'b1, 3, 1'b1, 1'b1);
      cycle(1'b1, 7, 1'b1, 1'b1);
      chk("bp_first_out", 32'(bus.out_onehot), 32'h0008);
      for (int i = 0; i < 4; i++) cycle(1'b1, 12, 1'b0, 1'b1);
      chk("bp_hold", 32'(bus.out_onehot), 32'h0008);
      cycle(1'b1, 12, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b1);
      chk("bp_drained", 32'(q.size()), 32'd0);

      // Random traffic, 1000 tokens.
      base  = n_acc;
      guard = 0;
      while ((n_acc - base) < 1000 && guard < 20000) begin
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'b1);
         guard++;
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b1);
      chk("rand_tokens", 32'(n_acc - base), 32'd1000);
      chk("rand_drained", 32'(q.size()), 32'd0);
      chk("in_eq_out", 32'(n_in_obs), 32'(n_out_obs));

      // Mid-operation reset drops two in-flight tokens.
      cycle(1'b1, 5, 1'b0, 1'b1);
      cycle(1'b1, 6, 1'b0, 1'b1);
      chk("mid_full", 32'(bus.out_valid), 32'd1);
      cycle(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b1);

      // Out-of-range index on the N=10 instance.
      bus2.in_valid = 1'b1;
      bus2.in_bin   = 4'd12;
      cycle(1'b0, 0, 1'b1, 1'b1);
      bus2.in_bin   = 4'd9;
      cycle(1'b0, 0, 1'b1, 1'b1);
      bus2.in_valid = 1'b0;
      chk("rc_valid_12", 32'(bus2.out_valid), 32'd1);
      chk("rc_onehot_12", 32'(bus2.out_onehot), 32'h000);
`ifdef BIN2OH_RANGE_CHECK_EN
      chk("rc_err_12", 32'(bus2.out_err), 32'd1);
`endif
      cycle(1'b0, 0, 1'b1, 1'b1);
      chk("rc_valid_9", 32'(bus2.out_valid), 32'd1);
      chk("rc_onehot_9", 32'(bus2.out_onehot), 32'h200);
`ifdef BIN2OH_RANGE_CHECK_EN
      chk("rc_err_9", 32'(bus2.out_err), 32'd0);
`endif
      cycle(1'b0, 0, 1'b1, 1'b1);
      chk("rc_empty", 32'(bus2.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
